// File: rtl/popcount_class_sequencer_pkg.sv
// Shared definitions for the popcount class sequencer.
// Contents: datapath widths, the FSM state encoding, and small helpers that
// turn the collected one-hot class vector into a class index and an error flag.
package popcount_class_sequencer_pkg;

  localparam int DATA_W    = 7;  // width of an input word
  localparam int CNT_OUT_W = 3;  // ones count of a 7-bit word fits in 3 bits
  localparam int SEL_W     = 2;  // mux select width
  localparam int NUM_CLASS = 4;  // number of classes / mux inputs

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the lowest set bit, 0 when no bit is set.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CLASS-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int k = NUM_CLASS - 1; k >= 0; k--) begin
      if (v[k]) r = k[SEL_W-1:0];
    end
    return r;
  endfunction

  // True when the vector is not exactly one-hot (none set, or several set).
  function automatic logic not_one_hot(input logic [NUM_CLASS-1:0] v);
    return (v == '0) || ((v & (v - 1'b1)) != '0);
  endfunction

endpackage

// File: rtl/popcount_class_sequencer_if.sv
// Handshake/bus interface of the popcount class sequencer.
// Input side : in_valid/in_ready/in_data (word source).
// Output side: out_valid/out_ready, out_count, out_class, out_onehot, out_err.
// Status     : busy, word_cnt (completed words), clr_cnt (clear word_cnt).
// slave modport is used by the sequencer, master by whoever drives it.
interface popcount_class_sequencer_if #(
  parameter int CNT_W = 8
);
  import popcount_class_sequencer_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_OUT_W-1:0] out_count;
  logic [SEL_W-1:0]     out_class;
  logic [NUM_CLASS-1:0] out_onehot;
  logic                 out_err;
  logic                 busy;
  logic [CNT_W-1:0]     word_cnt;
  logic                 clr_cnt;

  modport slave (
    input  in_valid, in_data, out_ready, clr_cnt,
    output in_ready, out_valid, out_count, out_class, out_onehot, out_err,
           busy, word_cnt
  );

  modport master (
    output in_valid, in_data, out_ready, clr_cnt,
    input  in_ready, out_valid, out_count, out_class, out_onehot, out_err,
           busy, word_cnt
  );

endinterface

// File: rtl/popcount_class_dp.sv
// Shared datapath: 7-bit ones-count encoder feeding a 4-way class-select mux.
// i_word : word being classified
// i_sel  : mux select (class index being probed)
// o_y    : ones count of i_word
// o_z    : 1 when the class of o_y equals i_sel
// The class of a count is the ones count of the count itself (0..3).
module popcount_class_dp
  import popcount_class_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0]    i_word,
  input  logic [SEL_W-1:0]     i_sel,
  output logic [CNT_OUT_W-1:0] o_y,
  output logic                 o_z
);

  logic [SEL_W-1:0]     w_class;
  logic [NUM_CLASS-1:0] w_class_dec;

  // Encoder: ones count of the word.
  always_comb begin
    o_y = '0;
    for (int b = 0; b < DATA_W; b++) begin
      o_y = o_y + CNT_OUT_W'(i_word[b]);
    end
  end

  // Class of the count: at most 3 ones in a 3-bit count, fits in SEL_W bits.
  assign w_class = SEL_W'(o_y[0]) + SEL_W'(o_y[1]) + SEL_W'(o_y[2]);

  // Mux inputs: one decoded line per class.
  for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_dec
    assign w_class_dec[gi] = (w_class == SEL_W'(gi));
  end

  assign o_z = w_class_dec[i_sel];

endmodule

// File: rtl/popcount_class_sequencer.sv
// Controller sequencing the shared popcount/class datapath.
// clk   : clock, rising edge
// rst_n : asynchronous active-low reset
// bus   : slave side of popcount_class_sequencer_if (handshakes, results,
//         busy, word_cnt, clr_cnt)
// A word accepted in IDLE is held while the mux select steps through the
// classes; each z response lands in one bit of a one-hot vector. The result
// is registered and presented until the consumer takes it.
module popcount_class_sequencer
  import popcount_class_sequencer_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input logic                        clk,
  input logic                        rst_n,
  popcount_class_sequencer_if.slave  bus
);

  state_t               r_state;
  state_t               w_state_next;
  logic [DATA_W-1:0]    r_data;
  logic [SEL_W-1:0]     r_sel;
  logic [CNT_OUT_W-1:0] r_count;
  logic [NUM_CLASS-1:0] r_onehot;
  logic                 r_out_valid;
  logic [CNT_OUT_W-1:0] r_out_count;
  logic [SEL_W-1:0]     r_out_class;
  logic [NUM_CLASS-1:0] r_out_onehot;
  logic                 r_out_err;
  logic [CNT_W-1:0]     r_word_cnt;

  logic [DATA_W-1:0]    w_word;
  logic [CNT_OUT_W-1:0] w_y;
  logic                 w_z;
  logic                 w_accept;
  logic                 w_hs;
  logic                 w_scan_end;

  // In IDLE the encoder sees the incoming word so its count can be captured
  // on the accept edge; afterwards it sees the held word.
  assign w_word = (r_state == IDLE) ? bus.in_data : r_data;

  popcount_class_dp u_dp (
    .i_word (w_word),
    .i_sel  (r_sel),
    .o_y    (w_y),
    .o_z    (w_z)
  );

  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_hs       = r_out_valid && bus.out_ready;
  assign w_scan_end = (r_sel == SEL_W'(NUM_CLASS - 1)) || (EARLY_EXIT && w_z);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_next = SCAN;
      SCAN:    if (w_scan_end) w_state_next = DONE;
      DONE:    if (w_hs)       w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_sel        <= '0;
      r_count      <= '0;
      r_onehot     <= '0;
      r_out_valid  <= 1'b0;
      r_out_count  <= '0;
      r_out_class  <= '0;
      r_out_onehot <= '0;
      r_out_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data   <= bus.in_data;
        r_count  <= w_y;
        r_onehot <= '0;
        r_sel    <= '0;
      end else if (r_state == SCAN) begin
        r_onehot[r_sel] <= w_z;
        r_sel           <= r_sel + 1'b1;
      end

      // First DONE cycle loads the result; out_valid rises one edge later.
      if (r_state == DONE && !r_out_valid) begin
        r_out_valid  <= 1'b1;
        r_out_count  <= r_count;
        r_out_onehot <= r_onehot;
        r_out_class  <= lowest_set(r_onehot);
        r_out_err    <= not_one_hot(r_onehot);
      end else if (w_hs) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  // Clear has priority over a coincident handshake increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_word_cnt <= '0;
    else if (bus.clr_cnt) r_word_cnt <= '0;
    else if (w_hs)        r_word_cnt <= r_word_cnt + 1'b1;
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_count  = r_out_count;
  assign bus.out_class  = r_out_class;
  assign bus.out_onehot = r_out_onehot;
  assign bus.out_err    = r_out_err;
  assign bus.word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_popcount_class_sequencer.sv
// Bench for popcount_class_sequencer: one instance with full scan and an
// 8-bit counter, one with early exit and a 2-bit counter. Expected results
// are queued when a word is driven and compared when the result appears.
module tb_popcount_class_sequencer;
  import popcount_class_sequencer_pkg::*;

  typedef struct {
    logic [2:0] count;
    logic [3:0] onehot;
    logic [1:0] cls;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [6:0] in_data = '0;
  bit         use_b = 1'b0;

  int   n_total = 0;
  int   n_pass = 0;
  int   exp_cnt_a = 0;
  int   exp_cnt_b = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  popcount_class_sequencer_if #(.CNT_W(8)) if_a ();
  popcount_class_sequencer_if #(.CNT_W(2)) if_b ();

  popcount_class_sequencer #(.CNT_W(8), .EARLY_EXIT(1'b0)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  popcount_class_sequencer #(.CNT_W(2), .EARLY_EXIT(1'b1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  assign if_a.in_valid  = in_valid & ~use_b;
  assign if_b.in_valid  = in_valid & use_b;
  assign if_a.in_data   = in_data;
  assign if_b.in_data   = in_data;
  assign if_a.out_ready = out_ready & ~use_b;
  assign if_b.out_ready = out_ready & use_b;
  assign if_a.clr_cnt   = clr_cnt & ~use_b;
  assign if_b.clr_cnt   = clr_cnt & use_b;

  logic       obs_valid, obs_ready, obs_busy, obs_err;
  logic [2:0] obs_count;
  logic [3:0] obs_onehot;
  logic [1:0] obs_class;
  logic [7:0] obs_cnt;

  assign obs_valid  = use_b ? if_b.out_valid  : if_a.out_valid;
  assign obs_ready  = use_b ? if_b.in_ready   : if_a.in_ready;
  assign obs_busy   = use_b ? if_b.busy       : if_a.busy;
  assign obs_err    = use_b ? if_b.out_err    : if_a.out_err;
  assign obs_count  = use_b ? if_b.out_count  : if_a.out_count;
  assign obs_onehot = use_b ? if_b.out_onehot : if_a.out_onehot;
  assign obs_class  = use_b ? if_b.out_class  : if_a.out_class;
  assign obs_cnt    = use_b ? {6'b0, if_b.word_cnt} : if_a.word_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model written from the class table, not from the datapath.
  function automatic exp_t model(input logic [6:0] w);
    exp_t e;
    e.count = 3'($countones(w));
    case (e.count)
      3'd0:                e.cls = 2'd0;
      3'd1, 3'd2, 3'd4:    e.cls = 2'd1;
      3'd3, 3'd5, 3'd6:    e.cls = 2'd2;
      default:             e.cls = 2'd3;
    endcase
    e.onehot = 4'b0001 << e.cls;
    e.lat    = use_b ? (int'(e.cls) + 2) : 5;
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the
  // output handshake has completed.
  task automatic xact(input logic [6:0] w, input int hold, input bit do_clr);
    exp_t e;
    exp_t got_e;
    int   k;
    e = model(w);
    sb.push_back(e);
    in_data  = w;
    in_valid = 1'b1;
    chk("in_ready_idle", obs_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_scan", obs_busy, 1);
    k = 0;
    while (!obs_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, e.lat);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      chk("hold_stable", {obs_valid, obs_ready, obs_count, obs_onehot},
          {1'b1, 1'b0, e.count, e.onehot});
      @(negedge clk);
    end
    in_valid = 1'b0;
    got_e = sb.pop_front();
    chk("out_count",  obs_count,  got_e.count);
    chk("out_onehot", obs_onehot, got_e.onehot);
    chk("out_class",  obs_class,  got_e.cls);
    chk("out_err",    obs_err,    0);
    out_ready = 1'b1;
    clr_cnt   = do_clr;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    if (use_b) exp_cnt_b = do_clr ? 0 : (exp_cnt_b + 1) % 4;
    else       exp_cnt_a = do_clr ? 0 : (exp_cnt_a + 1) % 256;
    chk("word_cnt", obs_cnt, use_b ? exp_cnt_b : exp_cnt_a);
    chk("in_ready_after", obs_ready, 1);
    chk("valid_drop", obs_valid, 0);
    $display("word %07b dut=%s count=%0d onehot=%04b class=%0d lat=%0d word_cnt=%0d",
             w, use_b ? "B" : "A", obs_count, obs_onehot, obs_class, k, obs_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_valid;
    // Reset held for 3 cycles, checked during and after.
    repeat (3) @(negedge clk);
    chk("rst_valid_a", if_a.out_valid, 0);
    chk("rst_ready_b", if_b.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      use_b = d[0];
      #1;
      chk("reset_valid", obs_valid, 0);
      chk("reset_busy", obs_busy, 0);
      chk("reset_cnt", obs_cnt, 0);
      chk("reset_ready", obs_ready, 1);
      chk("reset_onehot", obs_onehot, 0);
    end
    use_b = 1'b0;
    @(negedge clk);

    // Full scan: zero word, then back-to-back words.
    xact(7'b0000000, 0, 1'b0);
    xact(7'b0010110, 0, 1'b0);
    xact(7'b0101011, 0, 1'b0);
    xact(7'b1111111, 0, 1'b0);
    // Stalled consumer with in_valid pulsing.
    xact(7'b1010101, 10, 1'b0);
    // Clear coincident with a handshake.
    xact(7'b0000011, 0, 1'b1);
    xact(7'b1110000, 2, 1'b0);

    // Early exit with a 2-bit counter: four completions wrap to 0.
    use_b = 1'b1;
    @(negedge clk);
    xact(7'b0000000, 0, 1'b0);
    xact(7'b1111111, 0, 1'b0);
    xact(7'b0101011, 0, 1'b0);
    xact(7'b0010110, 3, 1'b0);
    chk("wrap_cnt", obs_cnt, 0);
    xact(7'b1000000, 0, 1'b0);
    xact(7'b0111111, 0, 1'b1);

    // Reset in the middle of a scan drops the word.
    use_b = 1'b0;
    @(negedge clk);
    in_data  = 7'b0110110;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", obs_busy, 0);
    chk("midrst_valid", obs_valid, 0);
    rst_n = 1'b1;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (obs_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_output", seen_valid, 0);
    chk("midrst_idle", obs_ready, 1);
    chk("midrst_cnt", obs_cnt, 0);
    xact(7'b0011001, 0, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
